spi_reg_bridge: RTL

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

---
 rtl/spi_reg_pkg.sv | 60 ++++++
 rtl/spi_busy_sync.sv | 41 ++++
 rtl/spi_reg_bridge.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_pkg.sv
// Shared types and field positions for the SPI-to-register bridge.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the command and readback-select encodings, the bridge FSM state
// type, the input_reg field map and the readback slice helper.
package spi_reg_pkg;

  localparam int CMD_W   = 4;   // command field width at the top of a frame
  localparam int SLICE_W = 12;  // meaningful data/readback width
  localparam int CNT_W   = 8;   // frame counter width

  // input_reg field map; bits 26:20 are never written
  localparam int LO_MSB  = 11;
  localparam int LO_LSB  = 0;
  localparam int MID_MSB = 19;
  localparam int MID_LSB = 12;
  localparam int B28_MSB = 28;
  localparam int B28_LSB = 27;
  localparam int B30_MSB = 30;
  localparam int B30_LSB = 29;
  localparam int B31     = 31;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP    = 4'd0,
    CMD_SEL    = 4'd1,
    CMD_WR_LO  = 4'd2,
    CMD_WR_MID = 4'd3,
    CMD_WR_B28 = 4'd4,
    CMD_WR_B30 = 4'd5,
    CMD_WR_B31 = 4'd6,
    CMD_CLR    = 4'd7
  } cmd_e;

  typedef enum logic [1:0] {
    SEL_STAT_LO   = 2'd0,
    SEL_STAT_MID  = 2'd1,
    SEL_STAT_HI   = 2'd2,
    SEL_FRAME_CNT = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DECODE  = 2'd2
  } state_e;

  // Readback slice chosen by the select register, always SLICE_W wide.
  function automatic logic [SLICE_W-1:0] readback_slice(input sel_e            sel,
                                                        input logic [31:0]      status,
                                                        input logic [CNT_W-1:0] cnt);
    case (sel)
      SEL_STAT_LO:  return status[11:0];
      SEL_STAT_MID: return status[23:12];
      SEL_STAT_HI:  return {4'b0000, status[31:24]};
      default:      return {4'b0000, cnt};
    endcase
  endfunction

endpackage

// File: rtl/spi_busy_sync.sv
// Busy-flag synchroniser with falling-edge detect, preset to "busy" in reset.
// Latency: DEPTH clk to busy_o; fall_o is valid the cycle busy_o first reads low.
// Backpressure: none; a free-running sampler.
//
// Ports:
//   clk, rst_n  clock, async active-low reset
//   busy_i      asynchronous busy flag from the SPI block
//   busy_o      synchronised level
//   fall_o      one-cycle pulse on a synchronised 1->0 transition
module spi_busy_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy_i,
  output logic busy_o,
  output logic fall_o
);

  logic [DEPTH-1:0] sync_q;
  logic             prev_q;
  // Fills with ones after reset; edge detection waits until every stage and
  // prev_q hold real samples, so the preset value never produces an edge.
  logic [DEPTH:0]   vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      vld_q  <= '0;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], busy_i};
      prev_q <= sync_q[DEPTH-1];
      vld_q  <= {vld_q[DEPTH-1:0], 1'b1};
    end
  end

  assign busy_o = sync_q[DEPTH-1];
  assign fall_o = vld_q[DEPTH] & prev_q & ~sync_q[DEPTH-1];

endmodule

// File: rtl/spi_reg_bridge.sv
// Decodes SPI command frames into a 32-bit control word and serves readback.
// Latency: input_reg/ctrl_update 2 clk after the FSM takes a synchronised rx edge.
// Backpressure: one frame may queue as pending; later edges are dropped with cmd_err.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   spi_data_rx  last received frame, stable while rx_busy low
//   rx_busy      receive busy; synchronised falling edge marks a new frame
//   tx_busy      transmit busy; spi_data_tx is frozen while it reads high
//   status_reg   status word sampled for readback
//   spi_data_tx  {select, readback slice} to the SPI transmitter
//   input_reg    control word; ctrl_update pulses on every write command
//   cmd_err      pulse on an illegal command or a dropped frame
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int FRAME_W     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FRAME_W-1:0] spi_data_rx,
  input  logic               rx_busy,
  input  logic               tx_busy,
  input  logic [31:0]        status_reg,
  output logic [FRAME_W-1:0] spi_data_tx,
  output logic [31:0]        input_reg,
  output logic               ctrl_update,
  output logic               cmd_err
);

  localparam int DATA_W = FRAME_W - CMD_W;

  logic rx_fall;
  logic tx_sync;
  logic unused_rx_busy;
  logic unused_tx_fall;

  spi_busy_sync #(.DEPTH(SYNC_STAGES)) u_rx_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .busy_i (rx_busy),
    .busy_o (unused_rx_busy),
    .fall_o (rx_fall)
  );

  spi_busy_sync #(.DEPTH(SYNC_STAGES)) u_tx_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .busy_i (tx_busy),
    .busy_o (tx_sync),
    .fall_o (unused_tx_fall)
  );

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic                 pending_q, pending_d;
  logic [31:0]          input_reg_q, input_reg_d;
  sel_e                 select_q, select_d;
  logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic                 ctrl_update_q, ctrl_update_d;
  logic                 cmd_err_q, cmd_err_d;
  logic [FRAME_W-1:0]   tx_q, tx_d;

  logic [CMD_W-1:0]     cmd;
  logic [SLICE_W-1:0]   wr_dat;

  assign cmd    = frame_q[FRAME_W-1 -: CMD_W];
  // Data bits above SLICE_W are ignored on write.
  assign wr_dat = frame_q[SLICE_W-1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (rx_fall) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_DECODE;
      // An edge arriving in DECODE itself is taken straight away, otherwise
      // it would set pending just as the FSM returned to IDLE.
      ST_DECODE:  state_d = (pending_q || rx_fall) ? ST_CAPTURE : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    frame_d       = frame_q;
    pending_d     = pending_q;
    input_reg_d   = input_reg_q;
    select_d      = select_q;
    frame_cnt_d   = frame_cnt_q;
    ctrl_update_d = 1'b0;
    cmd_err_d     = 1'b0;

    if (state_q == ST_CAPTURE) frame_d = spi_data_rx;

    if (state_q == ST_DECODE) begin
      // Leaving DECODE consumes one edge: either the stored one (and a new
      // edge takes its place) or the edge arriving now.
      pending_d = pending_q & rx_fall;
    end else if (state_q == ST_CAPTURE && rx_fall) begin
      if (pending_q) cmd_err_d = 1'b1;
      else           pending_d = 1'b1;
    end

    if (state_q == ST_DECODE) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
      case (cmd)
        CMD_NOP: begin
        end
        CMD_SEL: select_d = sel_e'(wr_dat[1:0]);
        CMD_WR_LO: begin
          input_reg_d[LO_MSB:LO_LSB] = wr_dat;
          ctrl_update_d = 1'b1;
        end
        CMD_WR_MID: begin
          input_reg_d[MID_MSB:MID_LSB] = wr_dat[7:0];
          ctrl_update_d = 1'b1;
        end
        CMD_WR_B28: begin
          input_reg_d[B28_MSB:B28_LSB] = wr_dat[1:0];
          ctrl_update_d = 1'b1;
        end
        CMD_WR_B30: begin
          input_reg_d[B30_MSB:B30_LSB] = wr_dat[1:0];
          ctrl_update_d = 1'b1;
        end
        CMD_WR_B31: begin
          input_reg_d[B31] = wr_dat[0];
          ctrl_update_d = 1'b1;
        end
        CMD_CLR: begin
          input_reg_d   = '0;
          ctrl_update_d = 1'b1;
        end
        default: cmd_err_d = 1'b1;
      endcase
    end

    // Readback reloads every cycle the transmitter is idle, so a select
    // written while busy shows up on the first idle cycle.
    tx_d = tx_sync ? tx_q
                   : {{2'b00, select_q},
                      DATA_W'(readback_slice(select_q, status_reg, frame_cnt_q))};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q       <= '0;
      pending_q     <= 1'b0;
      input_reg_q   <= '0;
      select_q      <= SEL_STAT_LO;
      frame_cnt_q   <= '0;
      ctrl_update_q <= 1'b0;
      cmd_err_q     <= 1'b0;
      tx_q          <= '0;
    end else begin
      frame_q       <= frame_d;
      pending_q     <= pending_d;
      input_reg_q   <= input_reg_d;
      select_q      <= select_d;
      frame_cnt_q   <= frame_cnt_d;
      ctrl_update_q <= ctrl_update_d;
      cmd_err_q     <= cmd_err_d;
      tx_q          <= tx_d;
    end
  end

  assign input_reg   = input_reg_q;
  assign ctrl_update = ctrl_update_q;
  assign cmd_err     = cmd_err_q;
  assign spi_data_tx = tx_q;

endmodule
